// File: rtl/syn_forward_scoreboard.sv
// ID-stage forwarding scoreboard: per-port youngest-producer select and load-use bubble.
// Outputs are combinational from registered slot state and rd_req/rd_used; no backpressure input.
module syn_forward_scoreboard #(
  parameter  int NUM_READ   = 2,
  parameter  int DEPTH      = 3,
  parameter  int REG_BITS   = 5,
  parameter  int LOAD_READY = 1,
  parameter  int CNT_BITS   = 16,
  localparam int SEL_BITS   = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         issue_w_en,
  input  logic [REG_BITS-1:0]          issue_w_req,
  input  logic                         issue_is_load,
  input  logic [NUM_READ*REG_BITS-1:0] rd_req,
  input  logic [NUM_READ-1:0]          rd_used,
  output logic [NUM_READ*SEL_BITS-1:0] fwd_sel,
  output logic                         bubble,
  output logic [CNT_BITS-1:0]          bubble_cnt
);

  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [DEPTH-1:0]    ld_q, ld_d;
  logic [REG_BITS-1:0] tag_q [DEPTH];
  logic [REG_BITS-1:0] tag_d [DEPTH];
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [SEL_BITS-1:0] sel_p;
  logic                haz_p;
  logic                kill;

  // Scan oldest to youngest so the youngest matching slot overwrites older ones.
  always_comb begin
    fwd_sel = '0;
    bubble  = 1'b0;
    sel_p   = '0;
    haz_p   = 1'b0;
    for (int p = 0; p < NUM_READ; p++) begin
      sel_p = '0;
      haz_p = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (rd_used[p] && vld_q[k] && (tag_q[k] != '0) &&
            (tag_q[k] == rd_req[p*REG_BITS +: REG_BITS])) begin
          sel_p = SEL_BITS'(k + 1);
          haz_p = ld_q[k] && (k < LOAD_READY);
        end
      end
      fwd_sel[p*SEL_BITS +: SEL_BITS] = sel_p;
      bubble = bubble | haz_p;
    end
  end

  // A held or killed ID instruction still lets older slots drain by one.
  always_comb begin
    kill     = bubble | stall | flush | ~issue_w_en | (issue_w_req == '0);
    vld_d    = '0;
    ld_d     = '0;
    vld_d[0] = ~kill;
    ld_d[0]  = ~kill & issue_is_load;
    tag_d[0] = kill ? '0 : issue_w_req;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      ld_d[k]  = ld_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
    cnt_d = cnt_q;
    if (bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_syn_forward_scoreboard.sv
// Bench for syn_forward_scoreboard: default instance (a) plus a 3-port, DEPTH=5, LOAD_READY=3, 2-bit counter instance (b).
module tb_syn_forward_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, stall, flush, issue_w_en, issue_is_load;
  logic [4:0]  issue_w_req;
  logic [9:0]  rd_req_a;
  logic [1:0]  rd_used_a;
  logic [3:0]  fwd_sel_a;
  logic        bubble_a;
  logic [15:0] cnt_a;
  logic [14:0] rd_req_b;
  logic [2:0]  rd_used_b;
  logic [8:0]  fwd_sel_b;
  logic        bubble_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  syn_forward_scoreboard u_a (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
    .issue_w_en(issue_w_en), .issue_w_req(issue_w_req), .issue_is_load(issue_is_load),
    .rd_req(rd_req_a), .rd_used(rd_used_a),
    .fwd_sel(fwd_sel_a), .bubble(bubble_a), .bubble_cnt(cnt_a)
  );

  syn_forward_scoreboard #(.NUM_READ(3), .DEPTH(5), .REG_BITS(5), .LOAD_READY(3), .CNT_BITS(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
    .issue_w_en(issue_w_en), .issue_w_req(issue_w_req), .issue_is_load(issue_is_load),
    .rd_req(rd_req_b), .rd_used(rd_used_b),
    .fwd_sel(fwd_sel_b), .bubble(bubble_b), .bubble_cnt(cnt_b)
  );

  typedef struct {
    logic en; logic w; logic [4:0] req; logic ld; logic st; logic fl;
    logic [4:0] r0; logic [4:0] r1; logic [1:0] u;
    logic [3:0] sel; logic bub; logic [15:0] cnt;
  } step_a_t;

  typedef struct {
    logic w; logic [4:0] req; logic ld;
    logic [4:0] r0; logic [4:0] r1; logic [4:0] r2; logic [2:0] u;
    logic [8:0] sel; logic bub; logic [1:0] cnt;
  } step_b_t;

  typedef struct { logic [3:0] sel; logic bub; logic [15:0] cnt; } exp_a_t;
  typedef struct { logic [8:0] sel; logic bub; logic [1:0] cnt; } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  function automatic step_a_t mk_a(logic en_v, logic w, logic [4:0] req, logic ld, logic st, logic fl,
                                   logic [4:0] r0, logic [4:0] r1, logic [1:0] u,
                                   logic [3:0] sel, logic bub, logic [15:0] cnt);
    step_a_t s;
    s.en = en_v; s.w = w; s.req = req; s.ld = ld; s.st = st; s.fl = fl;
    s.r0 = r0; s.r1 = r1; s.u = u; s.sel = sel; s.bub = bub; s.cnt = cnt;
    return s;
  endfunction

  function automatic step_b_t mk_b(logic w, logic [4:0] req, logic ld,
                                   logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [2:0] u,
                                   logic [8:0] sel, logic bub, logic [1:0] cnt);
    step_b_t s;
    s.w = w; s.req = req; s.ld = ld; s.r0 = r0; s.r1 = r1; s.r2 = r2; s.u = u;
    s.sel = sel; s.bub = bub; s.cnt = cnt;
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b1; stall = 1'b0; flush = 1'b0;
      issue_w_en = 1'b0; issue_w_req = '0; issue_is_load = 1'b0;
      rd_used_a = '0; rd_used_b = '0;
    end
  endtask

  // Drives one cycle of stimulus on instance a and records what it must produce.
  task automatic drive_a(input step_a_t s);
    @(negedge clk);
    en = s.en; stall = s.st; flush = s.fl;
    issue_w_en = s.w; issue_w_req = s.req; issue_is_load = s.ld;
    rd_req_a = {s.r1, s.r0}; rd_used_a = s.u; rd_used_b = '0;
    qa.push_back('{s.sel, s.bub, s.cnt});
  endtask

  task automatic drive_b(input step_b_t s);
    @(negedge clk);
    en = 1'b1; stall = 1'b0; flush = 1'b0;
    issue_w_en = s.w; issue_w_req = s.req; issue_is_load = s.ld;
    rd_req_b = {s.r2, s.r1, s.r0}; rd_used_b = s.u; rd_used_a = '0;
    qb.push_back('{s.sel, s.bub, s.cnt});
  endtask

  task automatic test_reset();
    exp_a_t ea;
    exp_b_t eb;
    repeat (3) begin
      @(negedge clk);
      rst = 1'b1; en = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
      issue_w_en = 1'($urandom); issue_w_req = 5'($urandom); issue_is_load = 1'($urandom);
      rd_req_a = 10'($urandom); rd_used_a = 2'($urandom);
      rd_req_b = 15'($urandom); rd_used_b = 3'($urandom);
    end
    qa.push_back('{4'h0, 1'b0, 16'h0});
    qb.push_back('{9'h0, 1'b0, 2'h0});
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    n_checks++; if (fwd_sel_a !== ea.sel) begin n_errors++; $display("FAIL reset_sel_a got %h want %h", fwd_sel_a, ea.sel); end
    n_checks++; if (bubble_a !== ea.bub) begin n_errors++; $display("FAIL reset_bub_a got %b want %b", bubble_a, ea.bub); end
    n_checks++; if (cnt_a !== ea.cnt) begin n_errors++; $display("FAIL reset_cnt_a got %0d want %0d", cnt_a, ea.cnt); end
    n_checks++; if (fwd_sel_b !== eb.sel) begin n_errors++; $display("FAIL reset_sel_b got %h want %h", fwd_sel_b, eb.sel); end
    n_checks++; if (bubble_b !== eb.bub) begin n_errors++; $display("FAIL reset_bub_b got %b want %b", bubble_b, eb.bub); end
    n_checks++; if (cnt_b !== eb.cnt) begin n_errors++; $display("FAIL reset_cnt_b got %0d want %0d", cnt_b, eb.cnt); end
    rst = 1'b0; en = 1'b1; stall = 1'b0; flush = 1'b0;
    issue_w_en = 1'b1; issue_w_req = 5'd8; issue_is_load = 1'b0;
    rd_used_a = '0; rd_used_b = '0;
    @(negedge clk);
    issue_w_en = 1'b0; issue_w_req = '0;
    rd_req_a = {5'd0, 5'd8}; rd_used_a = 2'b01;
    rd_req_b = {5'd0, 5'd0, 5'd8}; rd_used_b = 3'b001;
    qa.push_back('{4'h1, 1'b0, 16'h0});
    qb.push_back('{9'h1, 1'b0, 2'h0});
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    n_checks++; if (fwd_sel_a !== ea.sel) begin n_errors++; $display("FAIL post_reset_sel_a got %h want %h", fwd_sel_a, ea.sel); end
    n_checks++; if (fwd_sel_b !== eb.sel) begin n_errors++; $display("FAIL post_reset_sel_b got %h want %h", fwd_sel_b, eb.sel); end
  endtask

  task automatic test_forwarding();
    step_a_t s[$];
    exp_a_t  e;
    idle(3);
    s.push_back(mk_a(1, 1, 8,  0, 0, 0, 0,  0,  2'b00, 4'h0, 0, 0));
    s.push_back(mk_a(1, 1, 9,  0, 0, 0, 0,  0,  2'b00, 4'h0, 0, 0));
    s.push_back(mk_a(1, 1, 10, 0, 0, 0, 0,  0,  2'b00, 4'h0, 0, 0));
    s.push_back(mk_a(1, 0, 0,  0, 0, 0, 8,  10, 2'b11, 4'h7, 0, 0));
    s.push_back(mk_a(1, 1, 8,  0, 0, 0, 10, 0,  2'b01, 4'h2, 0, 0));
    s.push_back(mk_a(1, 1, 11, 0, 0, 0, 0,  0,  2'b00, 4'h0, 0, 0));
    s.push_back(mk_a(1, 1, 8,  0, 0, 0, 8,  11, 2'b11, 4'h6, 0, 0));
    s.push_back(mk_a(1, 0, 0,  0, 0, 0, 8,  11, 2'b11, 4'h9, 0, 0));
    foreach (s[i]) begin
      drive_a(s[i]);
      #1;
      e = qa.pop_front();
      n_checks++; if (fwd_sel_a !== e.sel) begin n_errors++; $display("FAIL fwd[%0d] sel got %h want %h", i, fwd_sel_a, e.sel); end
      n_checks++; if (bubble_a !== e.bub) begin n_errors++; $display("FAIL fwd[%0d] bubble got %b want %b", i, bubble_a, e.bub); end
    end
  endtask

  task automatic test_load_use();
    step_a_t s[$];
    exp_a_t  e;
    idle(3);
    s.push_back(mk_a(1, 1, 4, 1, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0));
    s.push_back(mk_a(1, 1, 5, 0, 0, 0, 0, 4, 2'b10, 4'h4, 1, 0));
    s.push_back(mk_a(1, 1, 5, 0, 0, 0, 0, 4, 2'b10, 4'h8, 0, 1));
    s.push_back(mk_a(1, 0, 0, 0, 0, 0, 0, 5, 2'b10, 4'h4, 0, 1));
    foreach (s[i]) begin
      drive_a(s[i]);
      #1;
      e = qa.pop_front();
      n_checks++; if (fwd_sel_a !== e.sel) begin n_errors++; $display("FAIL load_use[%0d] sel got %h want %h", i, fwd_sel_a, e.sel); end
      n_checks++; if (bubble_a !== e.bub) begin n_errors++; $display("FAIL load_use[%0d] bubble got %b want %b", i, bubble_a, e.bub); end
      n_checks++; if (cnt_a !== e.cnt) begin n_errors++; $display("FAIL load_use[%0d] cnt got %0d want %0d", i, cnt_a, e.cnt); end
    end
  endtask

  task automatic test_filters();
    step_a_t s[$];
    exp_a_t  e;
    idle(3);
    s.push_back(mk_a(1, 1, 0,  0, 0, 0, 0,  0,  2'b00, 4'h0, 0, 1));
    s.push_back(mk_a(1, 1, 12, 1, 0, 0, 0,  0,  2'b11, 4'h0, 0, 1));
    s.push_back(mk_a(1, 1, 13, 0, 0, 1, 12, 12, 2'b00, 4'h0, 0, 1));
    s.push_back(mk_a(1, 1, 14, 0, 1, 0, 13, 12, 2'b11, 4'h8, 0, 1));
    s.push_back(mk_a(1, 0, 15, 0, 0, 0, 14, 12, 2'b11, 4'hC, 0, 1));
    s.push_back(mk_a(1, 0, 0,  0, 0, 0, 15, 0,  2'b01, 4'h0, 0, 1));
    foreach (s[i]) begin
      drive_a(s[i]);
      #1;
      e = qa.pop_front();
      n_checks++; if (fwd_sel_a !== e.sel) begin n_errors++; $display("FAIL filter[%0d] sel got %h want %h", i, fwd_sel_a, e.sel); end
      n_checks++; if (bubble_a !== e.bub) begin n_errors++; $display("FAIL filter[%0d] bubble got %b want %b", i, bubble_a, e.bub); end
      n_checks++; if (cnt_a !== e.cnt) begin n_errors++; $display("FAIL filter[%0d] cnt got %0d want %0d", i, cnt_a, e.cnt); end
    end
  endtask

  task automatic test_en_gating();
    step_a_t s[$];
    exp_a_t  e;
    idle(3);
    s.push_back(mk_a(1, 1, 8, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1));
    s.push_back(mk_a(1, 1, 9, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1));
    repeat (5) s.push_back(mk_a(0, 1, 10, 0, 0, 0, 8, 9, 2'b11, 4'h6, 0, 1));
    s.push_back(mk_a(1, 1, 10, 0, 0, 0, 8, 9, 2'b11, 4'h6, 0, 1));
    s.push_back(mk_a(1, 0, 0,  0, 0, 0, 8, 9, 2'b11, 4'hB, 0, 1));
    foreach (s[i]) begin
      drive_a(s[i]);
      #1;
      e = qa.pop_front();
      n_checks++; if (fwd_sel_a !== e.sel) begin n_errors++; $display("FAIL en_gate[%0d] sel got %h want %h", i, fwd_sel_a, e.sel); end
      n_checks++; if (cnt_a !== e.cnt) begin n_errors++; $display("FAIL en_gate[%0d] cnt got %0d want %0d", i, cnt_a, e.cnt); end
    end
  endtask

  task automatic test_load_latency_sat();
    step_b_t s[$];
    exp_b_t  e;
    idle(5);
    s.push_back(mk_b(1, 4, 1, 0, 0, 0, 3'b000, 9'd0, 0, 0));
    s.push_back(mk_b(1, 5, 0, 4, 0, 0, 3'b001, 9'd1, 1, 0));
    s.push_back(mk_b(1, 5, 0, 4, 0, 0, 3'b001, 9'd2, 1, 1));
    s.push_back(mk_b(1, 5, 0, 4, 0, 0, 3'b001, 9'd3, 1, 2));
    s.push_back(mk_b(1, 5, 0, 4, 0, 0, 3'b001, 9'd4, 0, 3));
    s.push_back(mk_b(1, 6, 1, 0, 0, 0, 3'b000, 9'd0, 0, 3));
    s.push_back(mk_b(1, 7, 0, 6, 0, 0, 3'b001, 9'd1, 1, 3));
    s.push_back(mk_b(1, 7, 0, 6, 0, 0, 3'b001, 9'd2, 1, 3));
    s.push_back(mk_b(1, 7, 0, 6, 0, 0, 3'b001, 9'd3, 1, 3));
    s.push_back(mk_b(1, 7, 0, 6, 0, 0, 3'b001, 9'd4, 0, 3));
    foreach (s[i]) begin
      drive_b(s[i]);
      #1;
      e = qb.pop_front();
      n_checks++; if (fwd_sel_b !== e.sel) begin n_errors++; $display("FAIL latency[%0d] sel got %h want %h", i, fwd_sel_b, e.sel); end
      n_checks++; if (bubble_b !== e.bub) begin n_errors++; $display("FAIL latency[%0d] bubble got %b want %b", i, bubble_b, e.bub); end
      n_checks++; if (cnt_b !== e.cnt) begin n_errors++; $display("FAIL latency[%0d] cnt got %0d want %0d", i, cnt_b, e.cnt); end
    end
  endtask

  task automatic test_three_ports();
    step_b_t s[$];
    exp_b_t  e;
    idle(5);
    s.push_back(mk_b(1, 20, 0, 0,  0,  0,  3'b000, 9'h000, 0, 3));
    s.push_back(mk_b(1, 21, 0, 0,  0,  0,  3'b000, 9'h000, 0, 3));
    s.push_back(mk_b(1, 22, 1, 0,  0,  0,  3'b000, 9'h000, 0, 3));
    s.push_back(mk_b(0, 0,  0, 20, 21, 22, 3'b111, 9'h053, 1, 3));
    s.push_back(mk_b(0, 0,  0, 20, 21, 22, 3'b111, 9'h09C, 1, 3));
    foreach (s[i]) begin
      drive_b(s[i]);
      #1;
      e = qb.pop_front();
      n_checks++; if (fwd_sel_b !== e.sel) begin n_errors++; $display("FAIL three_port[%0d] sel got %h want %h", i, fwd_sel_b, e.sel); end
      n_checks++; if (bubble_b !== e.bub) begin n_errors++; $display("FAIL three_port[%0d] bubble got %b want %b", i, bubble_b, e.bub); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0;
    issue_w_en = 1'b0; issue_w_req = '0; issue_is_load = 1'b0;
    rd_req_a = '0; rd_used_a = '0; rd_req_b = '0; rd_used_b = '0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_filters();
    test_en_gating();
    test_load_latency_sat();
    test_three_ports();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
